amm1to2dec_async: RTL and testbench

AMM1TO2DEC_ASYNC -- requirements
Module: amm1to2dec_async

---
 rtl/amm1to2dec_async.sv | 112 +++++++++++
 tb/tb_amm1to2dec_async.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm1to2dec_async.sv
// Avalon-MM 1-to-2 address decoder with in-order read tracking and async active-low reset.
// Define AMM1TO2DEC_PIPELINE_EN to allow up to MAX_OUTSTANDING reads in flight (default: one).
module amm1to2dec_async #(
   parameter logic [31:0] S2_BASE         = 32'h0001_0000,
   parameter logic [31:0] S2_MASK         = 32'hFFFF_0000,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] s_address,
   input  logic [3:0]  s_byteenable,
   input  logic [31:0] s_writedata,
   input  logic        s_read,
   input  logic        s_write,
   output logic        s_waitrequest,
   output logic [31:0] s_readdata,
   output logic        s_readdatavalid,
   output logic [31:0] m1_address,
   output logic [3:0]  m1_byteenable,
   output logic [31:0] m1_writedata,
   output logic        m1_read,
   output logic        m1_write,
   input  logic        m1_waitrequest,
   input  logic [31:0] m1_readdata,
   input  logic        m1_readdatavalid,
   output logic [31:0] m2_address,
   output logic [3:0]  m2_byteenable,
   output logic [31:0] m2_writedata,
   output logic        m2_read,
   output logic        m2_write,
   input  logic        m2_waitrequest,
   input  logic [31:0] m2_readdata,
   input  logic        m2_readdatavalid,
   output logic        rsp_error
);

`ifdef AMM1TO2DEC_PIPELINE_EN
   localparam bit P_PIPE = 1'b1;
`else
   localparam bit P_PIPE = 1'b0;
`endif
   localparam int LIMIT = P_PIPE ? MAX_OUTSTANDING : 1;
   localparam int CNT_W = P_PIPE ? $clog2(MAX_OUTSTANDING + 1) : 1;
   localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_last_sel;
   logic             r_rsp_error;

   logic w_sel;
   logic w_busy;
   logic w_stall;
   logic w_tgt_wait;
   logic w_accept;
   logic w_m1_rsp_ok;
   logic w_m2_rsp_ok;
   logic w_return;
   logic w_spurious;

   assign w_sel      = ((s_address & S2_MASK) == S2_BASE);
   assign w_busy     = (r_cnt != '0);
   // Switching targets waits for all in-flight reads so responses cannot reorder.
   assign w_stall    = (r_cnt == C_LIMIT) | (w_busy & (w_sel != r_last_sel));
   assign w_tgt_wait = w_sel ? m2_waitrequest : m1_waitrequest;

   assign s_waitrequest = w_stall | w_tgt_wait;
   assign w_accept      = s_read & ~s_waitrequest;

   assign m1_address    = s_address;
   assign m1_byteenable = s_byteenable;
   assign m1_writedata  = s_writedata;
   assign m2_address    = s_address;
   assign m2_byteenable = s_byteenable;
   assign m2_writedata  = s_writedata;

   assign m1_read  = s_read  & ~w_sel & ~w_stall;
   assign m1_write = s_write & ~w_sel & ~w_stall;
   assign m2_read  = s_read  &  w_sel & ~w_stall;
   assign m2_write = s_write &  w_sel & ~w_stall;

   // Only the port owning the in-flight reads may return data; anything else is dropped.
   assign w_m1_rsp_ok = m1_readdatavalid & w_busy & ~r_last_sel;
   assign w_m2_rsp_ok = m2_readdatavalid & w_busy &  r_last_sel;
   assign w_return    = w_m1_rsp_ok | w_m2_rsp_ok;
   assign w_spurious  = (m1_readdatavalid & ~w_m1_rsp_ok) | (m2_readdatavalid & ~w_m2_rsp_ok);

   assign s_readdata      = r_last_sel ? m2_readdata : m1_readdata;
   assign s_readdatavalid = w_return;
   assign rsp_error       = r_rsp_error;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt       <= '0;
         r_last_sel  <= 1'b0;
         r_rsp_error <= 1'b0;
      end else begin
         if (w_accept & ~w_return) begin
            r_cnt <= r_cnt + C_ONE;
         end else if (~w_accept & w_return) begin
            r_cnt <= r_cnt - C_ONE;
         end
         if (w_accept) begin
            r_last_sel <= w_sel;
         end
         if (w_spurious) begin
            r_rsp_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_amm1to2dec_async.sv
// Self-checking bench for amm1to2dec_async: directed scenarios plus randomized traffic
// checked against a queue-based model of outstanding reads.
module tb_amm1to2dec_async;

   localparam logic [31:0] S2_BASE = 32'h0001_0000;
   localparam logic [31:0] S2_MASK = 32'hFFFF_0000;
`ifdef AMM1TO2DEC_PIPELINE_EN
   localparam int LIMIT = 4;
`else
   localparam int LIMIT = 1;
`endif

   logic        clk, resetn;
   logic [31:0] s_address, s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_read, s_write;
   logic        s_waitrequest, s_readdatavalid;
   logic [31:0] s_readdata;
   logic [31:0] m1_address, m1_writedata, m2_address, m2_writedata;
   logic [3:0]  m1_byteenable, m2_byteenable;
   logic        m1_read, m1_write, m2_read, m2_write;
   logic        m1_waitrequest, m2_waitrequest, m1_readdatavalid, m2_readdatavalid;
   logic [31:0] m1_readdata, m2_readdata;
   logic        rsp_error;

   int n_cmp = 0;
   int n_fail = 0;

   // Model: targets of reads in flight (oldest first) and sticky error flag.
   bit outq[$];
   bit m_err;
   bit e_wait, e_m1r, e_m2r, e_m1w, e_m2w, e_valid;
   logic [31:0] e_data;

   amm1to2dec_async #(.S2_BASE(S2_BASE), .S2_MASK(S2_MASK), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .resetn(resetn),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
      .s_read(s_read), .s_write(s_write),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .m2_address(m2_address), .m2_byteenable(m2_byteenable), .m2_writedata(m2_writedata),
      .m2_read(m2_read), .m2_write(m2_write), .m2_waitrequest(m2_waitrequest),
      .m2_readdata(m2_readdata), .m2_readdatavalid(m2_readdatavalid),
      .rsp_error(rsp_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit f_sel(input logic [31:0] a);
      return ((a & S2_MASK) == S2_BASE);
   endfunction

   function void compute_exp();
      bit sel, busy, stall;
      sel   = f_sel(s_address);
      busy  = (outq.size() != 0);
      stall = (outq.size() == LIMIT) || (busy && (sel != outq[0]));
      e_wait  = stall || (sel ? m2_waitrequest : m1_waitrequest);
      e_m1r   = s_read  && !sel && !stall;
      e_m2r   = s_read  &&  sel && !stall;
      e_m1w   = s_write && !sel && !stall;
      e_m2w   = s_write &&  sel && !stall;
      e_valid = busy && (outq[0] ? m2_readdatavalid : m1_readdatavalid);
      e_data  = (busy && outq[0]) ? m2_readdata : m1_readdata;
   endfunction

   task automatic model_reset();
      outq.delete();
      m_err = 1'b0;
   endtask

   task automatic model_update();
      bit busy, ok1, ok2, sel;
      if (!resetn) begin
         model_reset();
         return;
      end
      compute_exp();
      busy = (outq.size() != 0);
      sel  = f_sel(s_address);
      ok1  = m1_readdatavalid && busy && !outq[0];
      ok2  = m2_readdatavalid && busy &&  outq[0];
      if ((m1_readdatavalid && !ok1) || (m2_readdatavalid && !ok2)) m_err = 1'b1;
      if (e_valid) void'(outq.pop_front());
      if (s_read && !e_wait) outq.push_back(sel);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      s_address = '0; s_byteenable = '0; s_writedata = '0; s_read = 1'b0; s_write = 1'b0;
      m1_waitrequest = 1'b0; m2_waitrequest = 1'b0;
      m1_readdatavalid = 1'b0; m2_readdatavalid = 1'b0;
      m1_readdata = '0; m2_readdata = '0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle();
      tick();
      s_address = 32'h0001_0000;
      m1_readdatavalid = 1'b1; m2_readdatavalid = 1'b1;
      @(negedge clk);
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_wait got=%b exp=0", s_waitrequest); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", s_readdatavalid); end
      n_cmp++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
      n_cmp++; if ({m1_read, m2_read, m1_write, m2_write} !== 4'b0) begin n_fail++; $display("FAIL reset_cmds got=%b exp=0000", {m1_read, m2_read, m1_write, m2_write}); end
      tick();
      idle();
      resetn = 1'b1;
      s_address = $urandom; s_writedata = $urandom; s_byteenable = 4'($urandom);
      @(negedge clk);
      n_cmp++; if ({m1_address, m2_address} !== {s_address, s_address}) begin n_fail++; $display("FAIL pass_addr got=%h/%h exp=%h", m1_address, m2_address, s_address); end
      n_cmp++; if ({m1_writedata, m2_writedata} !== {s_writedata, s_writedata}) begin n_fail++; $display("FAIL pass_wdata got=%h/%h exp=%h", m1_writedata, m2_writedata, s_writedata); end
      n_cmp++; if ({m1_byteenable, m2_byteenable} !== {s_byteenable, s_byteenable}) begin n_fail++; $display("FAIL pass_be got=%h/%h exp=%h", m1_byteenable, m2_byteenable, s_byteenable); end
      tick();
      idle();
   endtask

   task automatic test_single_read();
      s_address = 32'h0000_0010; s_read = 1'b1;
      @(negedge clk);
      n_cmp++; if ({m1_read, m2_read, s_waitrequest} !== 3'b100) begin n_fail++; $display("FAIL single_issue got=%b exp=100", {m1_read, m2_read, s_waitrequest}); end
      tick();
      s_read = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", s_readdatavalid); end
         tick();
      end
      m1_readdatavalid = 1'b1; m1_readdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++; if (s_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", s_readdatavalid); end
      n_cmp++; if (s_readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data got=%h exp=deadbeef", s_readdata); end
      tick();
      m1_readdatavalid = 1'b0;
      s_address = 32'h0001_0000; s_read = 1'b1;
      @(negedge clk);
      n_cmp++; if ({m2_read, s_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL single_cnt_zero got=%b exp=10", {m2_read, s_waitrequest}); end
      tick();
      s_read = 1'b0; m2_readdatavalid = 1'b1; m2_readdata = 32'h1234_5678;
      @(negedge clk);
      n_cmp++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL single_m2_rsp got=%b/%h exp=1/12345678", s_readdatavalid, s_readdata); end
      tick();
      idle();
   endtask

   task automatic test_target_switch();
      int n_out;
      n_out = (LIMIT >= 2) ? 2 : 1;
      for (int i = 0; i < n_out; i++) begin
         s_address = 32'h20 + 32'(4 * i); s_read = 1'b1;
         @(negedge clk);
         n_cmp++; if ({m1_read, s_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL switch_m1_issue got=%b exp=10", {m1_read, s_waitrequest}); end
         tick();
      end
      s_read = 1'b0; s_write = 1'b1; s_address = 32'h0001_0004;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m2_write} !== 2'b10) begin n_fail++; $display("FAIL switch_write_stall got=%b exp=10", {s_waitrequest, m2_write}); end
      tick();
      s_write = 1'b0; s_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if ({s_waitrequest, m2_read} !== 2'b10) begin n_fail++; $display("FAIL switch_read_stall got=%b exp=10", {s_waitrequest, m2_read}); end
         tick();
      end
      for (int i = 0; i < n_out; i++) begin
         m1_readdatavalid = 1'b1; m1_readdata = 32'hA0 + 32'(i);
         @(negedge clk);
         n_cmp++; if ({s_readdatavalid, s_readdata, m2_read} !== {1'b1, 32'hA0 + 32'(i), 1'b0}) begin n_fail++; $display("FAIL switch_drain got=%b/%h/%b exp=1/%h/0", s_readdatavalid, s_readdata, m2_read, 32'hA0 + 32'(i)); end
         tick();
      end
      m1_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m2_read} !== 2'b01) begin n_fail++; $display("FAIL switch_release got=%b exp=01", {s_waitrequest, m2_read}); end
      tick();
      s_read = 1'b0; m2_readdatavalid = 1'b1; m2_readdata = 32'h0000_00BB;
      @(negedge clk);
      n_cmp++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'h0000_00BB}) begin n_fail++; $display("FAIL switch_m2_rsp got=%b/%h exp=1/000000bb", s_readdatavalid, s_readdata); end
      tick();
      idle();
   endtask

   task automatic test_spurious();
      m2_readdatavalid = 1'b1; m2_readdata = 32'h5555_AAAA;
      @(negedge clk);
      n_cmp++; if ({s_readdatavalid, rsp_error} !== 2'b00) begin n_fail++; $display("FAIL spur_drop got=%b exp=00", {s_readdatavalid, rsp_error}); end
      tick();
      m2_readdatavalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got=%b exp=1", rsp_error); end
         tick();
      end
      resetn = 1'b0; model_reset();
      #1;
      n_cmp++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL spur_reset_clear got=%b exp=0", rsp_error); end
      tick();
      resetn = 1'b1;
   endtask

`ifdef AMM1TO2DEC_PIPELINE_EN
   task automatic test_pipelined();
      s_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_address = 32'h0001_0000 + 32'(4 * i);
         @(negedge clk);
         n_cmp++; if ({s_waitrequest, m2_read} !== 2'b01) begin n_fail++; $display("FAIL pipe_accept%0d got=%b exp=01", i, {s_waitrequest, m2_read}); end
         tick();
      end
      s_address = 32'h0001_0010;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if ({s_waitrequest, m2_read} !== 2'b10) begin n_fail++; $display("FAIL pipe_full got=%b exp=10", {s_waitrequest, m2_read}); end
         tick();
      end
      m2_readdatavalid = 1'b1; m2_readdata = 32'hC0;
      @(negedge clk);
      n_cmp++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'hC0}) begin n_fail++; $display("FAIL pipe_first_rsp got=%b/%h exp=1/c0", s_readdatavalid, s_readdata); end
      tick();
      m2_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m2_read} !== 2'b01) begin n_fail++; $display("FAIL pipe_fifth got=%b exp=01", {s_waitrequest, m2_read}); end
      tick();
      s_read = 1'b0;
      for (int j = 0; j < 4; j++) begin
         m2_readdatavalid = 1'b1; m2_readdata = 32'hC1 + 32'(j);
         @(negedge clk);
         n_cmp++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'hC1 + 32'(j)}) begin n_fail++; $display("FAIL pipe_drain%0d got=%b/%h", j, s_readdatavalid, s_readdata); end
         tick();
      end
      idle();
   endtask

   task automatic test_simultaneous();
      s_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_address = 32'h40 + 32'(4 * i);
         @(negedge clk);
         n_cmp++; if ({s_waitrequest, m1_read} !== 2'b01) begin n_fail++; $display("FAIL simul_fill got=%b exp=01", {s_waitrequest, m1_read}); end
         tick();
      end
      s_address = 32'h48; m1_readdatavalid = 1'b1; m1_readdata = 32'hD0;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m1_read, s_readdatavalid} !== 3'b011) begin n_fail++; $display("FAIL simul_both got=%b exp=011", {s_waitrequest, m1_read, s_readdatavalid}); end
      tick();
      s_read = 1'b0;
      for (int j = 0; j < 2; j++) begin
         m1_readdata = 32'hD1 + 32'(j);
         @(negedge clk);
         n_cmp++; if ({s_readdatavalid, s_readdata} !== {1'b1, 32'hD1 + 32'(j)}) begin n_fail++; $display("FAIL simul_drain%0d got=%b/%h", j, s_readdatavalid, s_readdata); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL simul_extra got=%b exp=0", s_readdatavalid); end
      tick();
      m1_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL simul_error got=%b exp=1", rsp_error); end
      resetn = 1'b0; model_reset();
      tick();
      resetn = 1'b1;
      idle();
   endtask
`else
   task automatic test_macro_off();
      s_address = 32'h100; s_read = 1'b1;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m1_read} !== 2'b01) begin n_fail++; $display("FAIL off_first got=%b exp=01", {s_waitrequest, m1_read}); end
      tick();
      s_address = 32'h104;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if ({s_waitrequest, m1_read} !== 2'b10) begin n_fail++; $display("FAIL off_hold got=%b exp=10", {s_waitrequest, m1_read}); end
         tick();
      end
      m1_readdatavalid = 1'b1; m1_readdata = 32'hE0;
      @(negedge clk);
      n_cmp++; if ({s_readdatavalid, s_readdata, s_waitrequest} !== {1'b1, 32'hE0, 1'b1}) begin n_fail++; $display("FAIL off_rsp got=%b/%h/%b exp=1/e0/1", s_readdatavalid, s_readdata, s_waitrequest); end
      tick();
      m1_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++; if ({s_waitrequest, m1_read} !== 2'b01) begin n_fail++; $display("FAIL off_second got=%b exp=01", {s_waitrequest, m1_read}); end
      tick();
      s_address = 32'h0001_0000;
      resetn = 1'b0; model_reset();
      m1_readdatavalid = 1'b1;
      #1;
      n_cmp++; if ({s_readdatavalid, s_waitrequest} !== 2'b00) begin n_fail++; $display("FAIL off_reset_now got=%b exp=00", {s_readdatavalid, s_waitrequest}); end
      m1_readdatavalid = 1'b0; s_read = 1'b0;
      tick();
      resetn = 1'b1;
      m1_readdatavalid = 1'b1;
      @(negedge clk);
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL off_late_drop got=%b exp=0", s_readdatavalid); end
      tick();
      m1_readdatavalid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL off_late_error got=%b exp=1", rsp_error); end
      resetn = 1'b0; model_reset();
      tick();
      resetn = 1'b1;
      idle();
   endtask
`endif

   task automatic test_random();
      int op, reg_sel;
      for (int c = 0; c < 400; c++) begin
         idle();
         op = $urandom_range(0, 3);
         reg_sel = $urandom_range(0, 2);
         case (reg_sel)
            0:       s_address = {16'h0000, 16'($urandom)};
            1:       s_address = {16'h0001, 16'($urandom)};
            default: s_address = $urandom;
         endcase
         s_read  = (op == 1) || (op == 3);
         s_write = (op == 2);
         s_writedata = $urandom; s_byteenable = 4'($urandom);
         m1_waitrequest = ($urandom_range(0, 3) == 0);
         m2_waitrequest = ($urandom_range(0, 3) == 0);
         m1_readdata = $urandom; m2_readdata = $urandom;
         if (outq.size() != 0 && $urandom_range(0, 2) == 0) begin
            if (outq[0]) m2_readdatavalid = 1'b1;
            else m1_readdatavalid = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) begin
            if ($urandom_range(0, 1) == 0) m1_readdatavalid = 1'b1;
            else m2_readdatavalid = 1'b1;
         end
         @(negedge clk);
         compute_exp();
         n_cmp++; if (s_waitrequest !== e_wait) begin n_fail++; $display("FAIL rnd_wait c=%0d got=%b exp=%b", c, s_waitrequest, e_wait); end
         n_cmp++; if ({m1_read, m2_read, m1_write, m2_write} !== {e_m1r, e_m2r, e_m1w, e_m2w}) begin n_fail++; $display("FAIL rnd_cmds c=%0d got=%b exp=%b", c, {m1_read, m2_read, m1_write, m2_write}, {e_m1r, e_m2r, e_m1w, e_m2w}); end
         n_cmp++; if (s_readdatavalid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, s_readdatavalid, e_valid); end
         if (e_valid) begin
            n_cmp++; if (s_readdata !== e_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, s_readdata, e_data); end
         end
         n_cmp++; if (rsp_error !== m_err) begin n_fail++; $display("FAIL rnd_rsp_error c=%0d got=%b exp=%b", c, rsp_error, m_err); end
         n_cmp++; if (m2_address !== s_address) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, m2_address, s_address); end
         tick();
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_read();
      test_target_switch();
      test_spurious();
`ifdef AMM1TO2DEC_PIPELINE_EN
      test_pipelined();
      test_simultaneous();
`else
      test_macro_off();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
